// File: rtl/wb_uart_pkg.sv
// Shared register map and STATUS layout for the Wishbone UART port.
package wb_uart_pkg;

    // Byte offsets of the implemented registers
    localparam logic [3:0] OFFSET_DATA   = 4'h0;
    localparam logic [3:0] OFFSET_STATUS = 4'h4;

    // Register select decoded from adr_i[3:2]
    typedef enum logic [1:0] {
        REG_DATA   = OFFSET_DATA[3:2],
        REG_STATUS = OFFSET_STATUS[3:2],
        REG_RSVD_8 = 2'd2,
        REG_RSVD_C = 2'd3
    } reg_sel_e;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_OVERFLOW  = 3;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_FREE_LSB  = 16;

    // Bit of a DATA read that flags a valid received byte
    localparam int DATA_VALID_BIT = 8;

    // Map a Wishbone byte address onto a register select
    function automatic reg_sel_e reg_index(input logic [3:0] addr);
        return reg_sel_e'(addr[3:2]);
    endfunction

    // Assemble the STATUS word from FIFO state
    function automatic logic [31:0] build_status(
        input logic       rx_nonempty,
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_overflow,
        input logic [7:0] rx_count,
        input logic [7:0] tx_free
    );
        logic [31:0] s;
        s                           = 32'h0000_0000;
        s[ST_RX_NONEMPTY]           = rx_nonempty;
        s[ST_TX_FULL]               = tx_full;
        s[ST_TX_EMPTY]              = tx_empty;
        s[ST_RX_OVERFLOW]           = rx_overflow;
        s[ST_RX_COUNT_LSB +: 8]     = rx_count;
        s[ST_TX_FREE_LSB +: 8]      = tx_free;
        return s;
    endfunction

endpackage

// File: rtl/wb_uart_port_sync_fifo.sv
// Synchronous FIFO; callers must never push when full unless also popping.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage array; written only, never reset, contents qualified by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/wb_uart_port.sv
// Wishbone classic slave exposing a byte-stream UART-like port with TX/RX FIFOs.
module wb_uart_port
    import wb_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RX_DROP    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic          rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]    rx_head_s;
    logic [CW-1:0] tx_count_s, rx_count_s;
    logic          req_s, ack_s, err_s, ovf_clr_s, ovf_set_s;
    logic [31:0]   dat_s, status_s;
    logic          rx_overflow_r;
    logic          unused_s;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s),
        .wr_data(dat_i[7:0]), .rd_data(tx_data),
        .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_s), .pop(rx_pop_s),
        .wr_data(rx_data), .rd_data(rx_head_s),
        .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    assign status_s = build_status(~rx_empty_s, tx_full_s, tx_empty_s, rx_overflow_r,
                                   8'(rx_count_s), 8'(FIFO_DEPTH) - 8'(tx_count_s));

    // A new request is one not already terminated; reset suppresses it entirely
    assign req_s = stb_i & cyc_i & ~ack_o & ~err_o & ~rst;

    // Decode the request into termination, read data and FIFO side effects
    always_comb begin
        ack_s     = 1'b0;
        err_s     = 1'b0;
        dat_s     = 32'h0000_0000;
        tx_push_s = 1'b0;
        rx_pop_s  = 1'b0;
        ovf_clr_s = 1'b0;
        if (req_s) begin
            case (reg_index(adr_i))
                REG_DATA: begin
                    if (we_i) begin
                        if (sel_i[0] && tx_full_s) begin
                            err_s = 1'b1;
                        end else begin
                            ack_s     = 1'b1;
                            tx_push_s = sel_i[0];
                        end
                    end else begin
                        ack_s = 1'b1;
                        if (sel_i[0] && !rx_empty_s) begin
                            dat_s[DATA_VALID_BIT] = 1'b1;
                            dat_s[7:0]            = rx_head_s;
                            rx_pop_s              = 1'b1;
                        end else begin
                            dat_s = 32'h0000_0000;
                        end
                    end
                end
                REG_STATUS: begin
                    ack_s = 1'b1;
                    if (we_i) begin
                        ovf_clr_s = sel_i[0] & dat_i[ST_RX_OVERFLOW];
                    end else begin
                        dat_s = status_s;
                    end
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            ack_s = 1'b0;
        end
    end

    assign tx_valid  = ~tx_empty_s;
    assign tx_pop_s  = tx_valid & tx_ready & ~rst;
    assign rx_ready  = (RX_DROP != 32'sd0) ? 1'b1 : ~rx_full_s;
    // A full RX FIFO still accepts when the bus pops on the same edge
    assign rx_push_s = rx_valid & rx_ready & ~rst & (~rx_full_s | rx_pop_s);
    assign ovf_set_s = rx_valid & rx_ready & ~rst & rx_full_s & ~rx_pop_s;

    // Registered Wishbone termination, read data and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o         <= 1'b0;
            err_o         <= 1'b0;
            dat_o         <= 32'h0000_0000;
            rx_overflow_r <= 1'b0;
        end else begin
            ack_o <= ack_s;
            err_o <= err_s;
            dat_o <= ack_s ? dat_s : 32'h0000_0000;
            if (ovf_set_s) begin
                rx_overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                rx_overflow_r <= 1'b0;
            end else begin
                rx_overflow_r <= rx_overflow_r;
            end
        end
    end

    assign unused_s = ^{adr_i[1:0], sel_i[3:1], dat_i[31:8]};

endmodule

// File: tb/tb_wb_uart_port.sv
// Directed + randomized bench for wb_uart_port against a queue-based reference model.
module tb_wb_uart_port;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr_i = 4'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic        ack_o, err_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    logic [31:0] bp_dat_o;
    logic        bp_ack_o, bp_err_o, bp_tx_valid, bp_rx_ready;
    logic [7:0]  bp_tx_data;
    logic [7:0]  bp_rx_data = 8'h00;
    logic        bp_rx_valid = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ovf_m = 1'b0;

    always #5 clk = ~clk;

    wb_uart_port #(.FIFO_DEPTH(DEPTH), .RX_DROP(1)) dut (
        .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .sel_i(sel_i),
        .ack_o(ack_o), .err_o(err_o), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    wb_uart_port #(.FIFO_DEPTH(DEPTH), .RX_DROP(0)) dut_bp (
        .clk(clk), .rst(rst), .adr_i(4'h0), .dat_i(32'h0), .dat_o(bp_dat_o),
        .we_i(1'b0), .stb_i(1'b0), .cyc_i(1'b0), .sel_i(4'h0),
        .ack_o(bp_ack_o), .err_o(bp_err_o), .tx_data(bp_tx_data), .tx_valid(bp_tx_valid),
        .tx_ready(1'b0), .rx_data(bp_rx_data), .rx_valid(bp_rx_valid), .rx_ready(bp_rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (rx_q.size() != 0);
        s[1]     = (tx_q.size() == DEPTH);
        s[2]     = (tx_q.size() == 0);
        s[3]     = ovf_m;
        s[15:8]  = 8'(rx_q.size());
        s[23:16] = 8'(DEPTH - tx_q.size());
        return s;
    endfunction

    // One clock edge of the reference model: bus decode on pre-edge state, then stream effects
    task automatic model_edge(input bit bus_on, input logic [3:0] a, input logic w,
                              input logic [3:0] s, input logic [31:0] d, input logic trdy,
                              input logic rxv, input logic [7:0] rxd,
                              output logic e_ack, output logic e_err, output logic [31:0] e_dat);
        int  txn = tx_q.size();
        int  rxn = rx_q.size();
        bit  rxpop = 1'b0;
        bit  txpush = 1'b0;
        bit  clr = 1'b0;
        e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
        if (bus_on) begin
            if (a[3:2] == 2'd0) begin
                if (w) begin
                    if (s[0] && txn == DEPTH) e_err = 1'b1;
                    else begin e_ack = 1'b1; txpush = s[0]; end
                end else begin
                    e_ack = 1'b1;
                    if (s[0] && rxn > 0) begin e_dat = 32'h100 | 32'(rx_q[0]); rxpop = 1'b1; end
                end
            end else if (a[3:2] == 2'd1) begin
                e_ack = 1'b1;
                if (w) clr = s[0] && d[3];
                else e_dat = model_status();
            end else begin
                e_err = 1'b1;
            end
        end
        if (trdy && txn > 0) void'(tx_q.pop_front());
        if (txpush) tx_q.push_back(d[7:0]);
        if (rxpop) void'(rx_q.pop_front());
        if (clr) ovf_m = 1'b0;
        if (rxv) begin
            if (rxn < DEPTH || rxpop) rx_q.push_back(rxd);
            else ovf_m = 1'b1;
        end
    endtask

    // One Wishbone request plus optional same-edge stream activity, checked against the model
    task automatic bus(input logic [3:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                       input logic trdy, input logic rxv, input logic [7:0] rxd, input string tag,
                       output logic o_ack, output logic o_err, output logic [31:0] o_dat);
        logic e_ack, e_err;
        logic [31:0] e_dat;
        @(negedge clk);
        adr_i = a; we_i = w; sel_i = s; dat_i = d; stb_i = 1'b1; cyc_i = 1'b1;
        tx_ready = trdy; rx_valid = rxv; rx_data = rxd;
        model_edge(1'b1, a, w, s, d, trdy, rxv, rxd, e_ack, e_err, e_dat);
        @(posedge clk);
        @(negedge clk);
        o_ack = ack_o; o_err = err_o; o_dat = dat_o;
        chk({tag, ".ack"}, 32'(ack_o), 32'(e_ack));
        chk({tag, ".err"}, 32'(err_o), 32'(e_err));
        chk({tag, ".dat"}, dat_o, e_dat);
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    // One idle bus cycle with stream activity; checks the TX stream and idle bus outputs
    task automatic step(input logic trdy, input logic rxv, input logic [7:0] rxd, input string tag);
        logic e_ack, e_err;
        logic [31:0] e_dat;
        @(negedge clk);
        tx_ready = trdy; rx_valid = rxv; rx_data = rxd;
        chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) chk({tag, ".tx_data"}, 32'(tx_data), 32'(tx_q[0]));
        chk({tag, ".rx_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, ".idle_dat"}, dat_o, 32'h0);
        model_edge(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, trdy, rxv, rxd, e_ack, e_err, e_dat);
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    initial begin
        logic        a_k, e_k;
        logic [31:0] d_k;
        logic [7:0]  b;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.ack", 32'(ack_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        chk("rst.tx_valid", 32'(tx_valid), 32'd0);
        chk("rst.rx_ready", 32'(rx_ready), 32'd1);
        chk("rst.bp_rx_ready", 32'(bp_rx_ready), 32'd1);
        bus(4'h4, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, "rst_status", a_k, e_k, d_k);
        chk("rst.status", d_k, 32'h0008_0004);

        // Single TX write
        bus(4'h0, 1'b1, 4'h1, 32'h41, 1'b0, 1'b0, 8'h00, "wr41", a_k, e_k, d_k);
        chk("wr41.ack", 32'(a_k), 32'd1);
        chk("wr41.tx_valid", 32'(tx_valid), 32'd1);
        chk("wr41.tx_data", 32'(tx_data), 32'h41);
        bus(4'h4, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, "st41", a_k, e_k, d_k);
        chk("st41.status", d_k, 32'h0007_0000);

        // sel_i[0]=0 write is a no-op, then fill TX and overrun it
        bus(4'h0, 1'b1, 4'hE, $urandom, 1'b0, 1'b0, 8'h00, "wr_nosel", a_k, e_k, d_k);
        for (int i = 0; i < 7; i++)
            bus(4'h0, 1'b1, 4'h1, $urandom, 1'b0, 1'b0, 8'h00, "wr_fill", a_k, e_k, d_k);
        bus(4'h0, 1'b1, 4'h1, 32'hEE, 1'b0, 1'b0, 8'h00, "wr_full", a_k, e_k, d_k);
        chk("wr_full.err", 32'(e_k), 32'd1);
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "st_full", a_k, e_k, d_k);
        chk("st_full.tx_full", 32'(d_k[1]), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, "drain");
        chk("drain.tx_valid", 32'(tx_valid), 32'd0);
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "st_drain", a_k, e_k, d_k);
        chk("st_drain.tx_empty", 32'(d_k[2]), 32'd1);

        // Same-edge push and drain
        bus(4'h0, 1'b1, 4'h1, 32'h11, 1'b0, 1'b0, 8'h00, "pd1", a_k, e_k, d_k);
        bus(4'h0, 1'b1, 4'h1, 32'h22, 1'b0, 1'b0, 8'h00, "pd2", a_k, e_k, d_k);
        bus(4'h0, 1'b1, 4'h1, 32'h33, 1'b1, 1'b0, 8'h00, "pd3", a_k, e_k, d_k);
        chk("pd.tx_data", 32'(tx_data), 32'h22);
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "pd_st", a_k, e_k, d_k);
        chk("pd.status", d_k, 32'h0006_0000);
        step(1'b1, 1'b0, 8'h00, "pd_drain");
        step(1'b1, 1'b0, 8'h00, "pd_drain");

        // RX path
        step(1'b0, 1'b1, 8'h55, "rx55");
        step(1'b0, 1'b1, 8'hAA, "rxAA");
        bus(4'h0, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "rd1", a_k, e_k, d_k);
        chk("rd1.val", d_k, 32'h155);
        bus(4'h0, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "rd2", a_k, e_k, d_k);
        chk("rd2.val", d_k, 32'h1AA);
        bus(4'h0, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "rd3", a_k, e_k, d_k);
        chk("rd3.val", d_k, 32'h0);
        chk("rd3.ack", 32'(a_k), 32'd1);

        // Overflow, ignored status write bits, clear
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'($urandom), "rx_ovf");
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "st_ovf", a_k, e_k, d_k);
        chk("st_ovf.status", d_k, 32'h0008_080D);
        bus(4'h4, 1'b1, 4'h1, $urandom & 32'hFFFF_FFF7, 1'b0, 1'b0, 8'h00, "st_wr_ign", a_k, e_k, d_k);
        bus(4'h4, 1'b1, 4'h1, 32'h8, 1'b0, 1'b0, 8'h00, "st_clr", a_k, e_k, d_k);
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "st_clr_rd", a_k, e_k, d_k);
        chk("st_clr.status", d_k, 32'h0008_0805);

        // Full RX: bus pop and rx push on the same edge
        bus(4'h0, 1'b0, 4'h1, 32'h0, 1'b0, 1'b1, 8'h33, "rd_push", a_k, e_k, d_k);
        bus(4'h4, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "rd_push_st", a_k, e_k, d_k);
        chk("rd_push.status", d_k, 32'h0008_0805);
        for (int i = 0; i < DEPTH; i++)
            bus(4'h0, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 8'h00, "rx_drain", a_k, e_k, d_k);
        chk("rx_drain.last", d_k, 32'h133);

        // Backpressure variant
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("bp.rx_ready_open", 32'(bp_rx_ready), 32'd1);
            bp_rx_valid = 1'b1; bp_rx_data = 8'($urandom);
        end
        @(negedge clk);
        bp_rx_valid = 1'b0;
        chk("bp.rx_ready_full", 32'(bp_rx_ready), 32'd0);

        // Randomized mixed traffic
        for (int i = 0; i < 120; i++) begin
            logic [3:0] ra;
            ra = ($urandom_range(0, 9) < 8) ? {1'b0, 1'($urandom), 2'b00} : {2'b10 | 2'($urandom), 2'b00};
            bus(ra, 1'($urandom), 4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0),
                1'($urandom), 8'($urandom), "rand", a_k, e_k, d_k);
        end

        // Reserved offsets
        bus(4'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, "rsv8", a_k, e_k, d_k);
        chk("rsv8.err", 32'(e_k), 32'd1);
        bus(4'hC, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, "rsvC", a_k, e_k, d_k);
        chk("rsvC.dat", d_k, 32'h0);
        bus(4'hC, 1'b1, 4'hF, $urandom, 1'b0, 1'b0, 8'h00, "rsvC_wr", a_k, e_k, d_k);

        // Reset in the middle of a request
        @(negedge clk);
        adr_i = 4'h0; we_i = 1'b1; sel_i = 4'h1; dat_i = 32'h77; stb_i = 1'b1; cyc_i = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h99; tx_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.ack", 32'(ack_o), 32'd0);
        chk("rst_mid.err", 32'(err_o), 32'd0);
        chk("rst_mid.dat", dat_o, 32'h0);
        chk("rst_mid.tx_valid", 32'(tx_valid), 32'd0);
        stb_i = 1'b0; cyc_i = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rst = 1'b0;
        tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;
        bus(4'h4, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, "rst_mid_st", a_k, e_k, d_k);
        chk("rst_mid.status", d_k, 32'h0008_0004);
        chk("rst_mid.bp_rx_ready", 32'(bp_rx_ready), 32'd1);
        bus(4'h0, 1'b1, 4'h1, 32'h77, 1'b0, 1'b0, 8'h00, "retry", a_k, e_k, d_k);
        chk("retry.tx_data", 32'(tx_data), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_uart_port.md
WB_UART_PORT -- requirements
Module: wb_uart_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX and RX FIFO (power of two, 2..128).
REQ-002 SHALL have parameter RX_DROP, default 1, meaning 1 = rx_ready always high and drop on full, 0 = backpressure rx_ready.
REQ-003 SHALL have port clk  in  1  meaning the single clock for all logic.
REQ-004 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port adr_i  in  4  meaning the Wishbone byte address; bits [3:2] select the register.
REQ-006 SHALL have ports dat_i in 32 / dat_o out 32, meaning Wishbone write and read data.
REQ-007 SHALL have ports we_i, stb_i and cyc_i, each in 1, plus sel_i in 4, meaning the Wishbone classic request signals.
REQ-008 SHALL have ports ack_o and err_o, each out 1, meaning Wishbone termination.
REQ-009 SHALL have ports tx_data out 8, tx_valid out 1 and tx_ready in 1, meaning the byte stream from core to tty.
REQ-010 SHALL have ports rx_data in 8, rx_valid in 1 and rx_ready out 1, meaning the byte stream from tty to core.

Function
REQ-011 SHALL register termination: a request (stb_i & cyc_i & !ack_o & !err_o) at edge N asserts exactly one of ack_o/err_o for the single cycle after N.
REQ-012 SHALL perform all side effects (push, pop, clear) on the same edge that registers ack_o, and never on an edge that registers err_o.
REQ-013 SHALL NOT terminate a request twice; a second termination requires stb_i to remain or return high after the previous termination cycle.
REQ-014 SHALL map DATA to offset 0x0: a write with sel_i[0]=1 pushes dat_i[7:0] to TX and acks; a write with sel_i[0]=0 acks with no effect.
REQ-015 SHALL answer a DATA write while the TX FIFO is full, judged by pre-edge state, with err_o, push nothing, and ignore a same-edge drain.
REQ-016 SHALL answer a DATA read with sel_i[0]=1 and RX non-empty with dat_o={23'b0,1'b1,head}, pop RX and ack.
REQ-017 SHALL answer a DATA read with RX empty, or with sel_i[0]=0, with dat_o=0 and ack, popping nothing.
REQ-018 SHALL map STATUS to offset 0x4, read as [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] rx_overflow, [15:8] rx_count, [23:16] tx_free, and all other bits 0.
REQ-019 SHALL clear rx_overflow and ack on a STATUS write with sel_i[0]=1 and dat_i[3]=1; all other STATUS write bits are ignored.
REQ-020 SHALL answer offsets 0x8 and 0xC, reads and writes, with err_o.
REQ-021 SHALL hold dat_o at 0 in every cycle without ack_o.
REQ-022 SHALL drive tx_valid = TX non-empty and tx_data = TX head, combinationally from FIFO state, and pop TX on tx_valid & tx_ready.
REQ-023 SHALL, when RX_DROP=1, hold rx_ready=1; on rx_valid with RX full, drop the byte and set sticky rx_overflow.
REQ-024 SHALL, when RX_DROP=0, drive rx_ready = !RX full, so rx_overflow never sets.
REQ-025 SHALL, when RX_DROP=1 and RX is full, accept an rx push on the same edge as a bus pop, leaving the count unchanged and rx_overflow not set.
REQ-026 SHALL let a same-edge bus push and tx drain both take effect, with correct counts and no TX data loss.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH; counts SHALL be log2(FIFO_DEPTH)+1 bits, zero-extended into the STATUS fields.

Reset
REQ-028 SHALL on rst empty both FIFOs and clear rx_overflow, ack_o, err_o, dat_o and tx_valid to 0, with rx_ready driven per REQ-023/024.
REQ-029 SHALL drop a termination pending at a mid-transaction rst; the master SHALL retry, and no side effect from the dropped request occurs.
REQ-030 SHALL accept no rx byte and issue no tx pop on any edge where rst is high.

Structure
REQ-031 SHALL place the register offsets (0x0, 0x4), the STATUS bit positions and the DATA valid-bit position in shared package wb_uart_pkg.
REQ-032 SHALL implement each FIFO as instances of one sub-module, sync_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty/count), one for TX and one for RX.

Verification
REQ-033 SHALL cover: write DATA 0x41 sel=0x1 with tx_ready=0 -> ack next cycle; tx_valid=1, tx_data=0x41; STATUS=0x00070000 with FIFO_DEPTH=8.
REQ-034 SHALL cover: 9 DATA writes with tx_ready=0 -> 8 acks, 9th err_o, STATUS[1]=1; then tx_ready=1 for 8 cycles -> bytes out in order, tx_empty=1.
REQ-035 SHALL cover: rx 0x55, 0xAA, then read DATA three times -> dat_o 0x155, 0x1AA, then 0x0, all acked.
REQ-036 SHALL cover: RX_DROP=1, 9 rx bytes -> STATUS[3]=1 and rx_count=8; STATUS write 0x8 sel=0x1 -> STATUS[3]=0.
REQ-037 SHALL cover: RX full and a DATA read on the same edge as rx_valid 0x33 -> head returned, count stays 8, no overflow; RX_DROP=0 full -> rx_ready=0.
REQ-038 SHALL cover: reads of 0x8 and 0xC -> err_o, dat_o=0; rst asserted mid-request -> no ack and FIFOs empty.
